// File: rtl/hue_calc_multi.sv
// rtl/hue_calc_multi.sv - multi-channel note-position to hue mapper
// Piecewise-linear map over three segments, one shared multiplier time-multiplexed per channel.
module hue_calc_multi #(
  parameter int W               = 6,
  parameter int D               = 10,
  parameter int NUM_CH          = 12,
  parameter int BINS_PER_OCTAVE = 24,
  parameter int SEG_B1          = 8192,
  parameter int SEG_B2          = 16384,
  parameter int HUE0            = 0,
  parameter int HUE1            = 341,
  parameter int HUE2            = 682,
  parameter int SLOPE_W         = 16,
  parameter int SLOPE_FRAC      = 16,
  parameter int SLOPE0          = 2728,
  parameter int SLOPE1          = 2728,
  parameter int SLOPE2          = 2736
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [NUM_CH*(W+D)-1:0]    pos_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [NUM_CH*D-1:0]        hue_o,
  output logic [NUM_CH-1:0]          range_err_o
);

  localparam int PW = W + D;
  localparam int MW = PW + SLOPE_W;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [PW:0]         POS_SPAN = (PW+1)'(BINS_PER_OCTAVE << D);
  localparam logic [PW-1:0]       B1       = PW'(SEG_B1);
  localparam logic [PW-1:0]       B2       = PW'(SEG_B2);
  localparam logic [D-1:0]        H0       = D'(HUE0);
  localparam logic [D-1:0]        H1       = D'(HUE1);
  localparam logic [D-1:0]        H2       = D'(HUE2);
  localparam logic [SLOPE_W-1:0]  K0       = SLOPE_W'(SLOPE0);
  localparam logic [SLOPE_W-1:0]  K1       = SLOPE_W'(SLOPE1);
  localparam logic [SLOPE_W-1:0]  K2       = SLOPE_W'(SLOPE2);
  localparam logic [CW-1:0]       LAST_CH  = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [NUM_CH*PW-1:0]     r_frame;
  logic [CW-1:0]            r_ch;
  logic                     w_issue;

  logic [PW-1:0]            w_pos;
  logic [PW-1:0]            w_off;
  logic [SLOPE_W-1:0]       w_slope;
  logic [D-1:0]             w_base;
  logic                     w_err;

  logic                     r_s1_vld;
  logic [CW-1:0]            r_s1_ch;
  logic [PW-1:0]            r_s1_off;
  logic [SLOPE_W-1:0]       r_s1_slope;
  logic [D-1:0]             r_s1_base;
  logic                     r_s1_err;

  logic [MW-1:0]            w_prod;
  logic                     r_s2_vld;
  logic [CW-1:0]            r_s2_ch;
  logic [MW-1:0]            r_s2_prod;
  logic [D-1:0]             r_s2_base;
  logic                     r_s2_err;

  logic [D-1:0]             w_hue;
  logic [NUM_CH*D-1:0]      r_hue;
  logic [NUM_CH-1:0]        r_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid_i)              w_state_nxt = S_RUN;
      S_RUN:   if (r_ch == LAST_CH)         w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_s1_vld && !r_s2_vld)  w_state_nxt = S_DONE;
      S_DONE:  if (out_ready_i)             w_state_nxt = S_IDLE;
      default:                              w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready_o  = (r_state == S_IDLE);
  assign out_valid_o = (r_state == S_DONE);
  assign w_issue     = (r_state == S_RUN);

  always_ff @(posedge clk) begin
    if (in_ready_o && in_valid_i) r_frame <= pos_i;
  end

  always_ff @(posedge clk) begin
    if (rst)          r_ch <= '0;
    else if (w_issue) r_ch <= (r_ch == LAST_CH) ? '0 : r_ch + 1'b1;
  end

  // S1: segment select; out-of-range positions fall into segment 2 and wrap later
  assign w_pos = r_frame[r_ch*PW +: PW];

  always_comb begin
    w_off   = w_pos;
    w_slope = K0;
    w_base  = H0;
    if (w_pos >= B2) begin
      w_off   = w_pos - B2;
      w_slope = K2;
      w_base  = H2;
    end else if (w_pos >= B1) begin
      w_off   = w_pos - B1;
      w_slope = K1;
      w_base  = H1;
    end
    w_err = ({1'b0, w_pos} >= POS_SPAN);
  end

  always_ff @(posedge clk) begin
    if (rst) r_s1_vld <= 1'b0;
    else     r_s1_vld <= w_issue;
    r_s1_ch    <= r_ch;
    r_s1_off   <= w_off;
    r_s1_slope <= w_slope;
    r_s1_base  <= w_base;
    r_s1_err   <= w_err;
  end

  // S2: the only multiplier in the block
  assign w_prod = MW'(r_s1_off) * MW'(r_s1_slope);

  always_ff @(posedge clk) begin
    if (rst) r_s2_vld <= 1'b0;
    else     r_s2_vld <= r_s1_vld;
    r_s2_ch   <= r_s1_ch;
    r_s2_prod <= w_prod;
    r_s2_base <= r_s1_base;
    r_s2_err  <= r_s1_err;
  end

  // S3: truncation to D bits gives the modulo-2^D hue wrap
  assign w_hue = r_s2_base + D'(r_s2_prod >> SLOPE_FRAC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hue <= '0;
      r_err <= '0;
    end else if (r_s2_vld) begin
      r_hue[r_s2_ch*D +: D] <= w_hue;
      r_err[r_s2_ch]        <= r_s2_err;
    end
  end

  assign hue_o       = r_hue;
  assign range_err_o = r_err;

endmodule

// File: tb/tb_hue_calc_multi.sv
// tb/tb_hue_calc_multi.sv - self-checking bench for hue_calc_multi
// Directed frames plus random frames scored against an arithmetic hue model.
module tb_hue_calc_multi;

  localparam int N  = 12;
  localparam int D  = 10;
  localparam int PW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [N*PW-1:0]      pos = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [N*D-1:0]       hue;
  logic [N-1:0]         range_err;

  int checks = 0;
  int failures = 0;

  hue_calc_multi dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .pos_i       (pos),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .hue_o       (hue),
    .range_err_o (range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_hue(input int p);
    longint base, off, slope;
    if (p < 8192) begin
      base = 0;   off = p;         slope = 2728;
    end else if (p < 16384) begin
      base = 341; off = p - 8192;  slope = 2728;
    end else begin
      base = 682; off = p - 16384; slope = 2736;
    end
    return int'((base + (off * slope) / 65536) % 1024);
  endfunction

  function automatic int ref_err(input int p);
    return (p >= 24 * 1024) ? 1 : 0;
  endfunction

  function automatic logic [N*PW-1:0] rand_frame();
    logic [N*PW-1:0] f;
    int v;
    for (int k = 0; k < N; k++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom_range(0, 65535);
        1: case ($urandom_range(0, 5))
             0: v = 0;
             1: v = 8192;
             2: v = 16384;
             3: v = 24575;
             4: v = 24576;
             default: v = 8191;
           endcase
        default: v = $urandom_range(0, 24575);
      endcase
      f[k*PW +: PW] = PW'(v);
    end
    return f;
  endfunction

  task automatic check_frame(input string tag, input logic [N*PW-1:0] f);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_hue%0d", tag, k), 32'(hue[k*D +: D]), ref_hue(int'(f[k*PW +: PW])));
      check($sformatf("%s_err%0d", tag, k), 32'(range_err[k]), ref_err(int'(f[k*PW +: PW])));
    end
  endtask

  task automatic send(input logic [N*PW-1:0] f);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); @(negedge clk); n++;
    end
    if (n >= 200) check("send_timeout", 1, 0);
    pos = f;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk); lat++; @(negedge clk);
    end while (!out_valid && lat < 200);
    if (lat >= 200) check("out_timeout", 1, 0);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [N*PW-1:0] f1, f2, f3;
  logic [N*PW-1:0] bb [4];
  logic [N*D-1:0]  snap_hue;
  logic [N-1:0]    snap_err;
  int lat, cnt, idx, outs, cyc, last_cyc;
  int exp1 [4] = '{0, 170, 511, 1023};

  initial begin
    // Reset
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_hue_zero", 32'(|hue), 0);
    check("rst_err_zero", 32'(|range_err), 0);
    rst = 1'b0;

    // Directed frame 1
    f1 = '0;
    for (int k = 0; k < N; k++) f1[k*PW +: PW] = 16'd8192;
    f1[0*PW +: PW] = 16'd0;
    f1[1*PW +: PW] = 16'd4096;
    f1[2*PW +: PW] = 16'd12288;
    f1[3*PW +: PW] = 16'd24575;
    send(f1);
    wait_out(lat);
    check("d1_latency", lat, N + 3);
    for (int k = 0; k < N; k++)
      check($sformatf("d1_hue%0d", k), 32'(hue[k*D +: D]), (k < 4) ? exp1[k] : 341);
    check("d1_err", 32'(range_err), 0);
    take();

    // Directed frame 2: segment-2 start and an out-of-range position
    f2 = rand_frame();
    for (int k = 2; k < N; k++) f2[k*PW +: PW] = PW'($urandom_range(0, 24575));
    f2[0*PW +: PW] = 16'd16384;
    f2[1*PW +: PW] = 16'd30000;
    send(f2);
    wait_out(lat);
    check("d2_hue0", 32'(hue[0 +: D]), 682);
    check("d2_hue1", 32'(hue[D +: D]), 226);
    check("d2_err", 32'(range_err), 32'h2);
    check_frame("d2", f2);
    take();

    // Backpressure in DONE with a competing input request
    f1 = rand_frame();
    f3 = rand_frame();
    send(f1);
    wait_out(lat);
    check_frame("bp_a", f1);
    snap_hue = hue;
    snap_err = range_err;
    pos = f3;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("bp_valid%0d", i), 32'(out_valid), 1);
      check($sformatf("bp_ready%0d", i), 32'(in_ready), 0);
      check($sformatf("bp_stable%0d", i), 32'((hue == snap_hue) && (range_err == snap_err)), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("bp_rel_ready", 32'(in_ready), 1);
    check("bp_rel_valid", 32'(out_valid), 0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("bp_accepted", 32'(in_ready), 0);
    wait_out(lat);
    check("bp_latency", lat, N + 3);
    check_frame("bp_b", f3);
    take();

    // Reset three cycles into RUN aborts the frame
    send(rand_frame());
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < N + 10; i++) begin
      if (out_valid) cnt++;
      @(posedge clk); @(negedge clk);
    end
    check("abort_no_out", cnt, 0);
    check("abort_ready", 32'(in_ready), 1);
    f1 = rand_frame();
    send(f1);
    wait_out(lat);
    check("post_rst_latency", lat, N + 3);
    check_frame("post_rst", f1);
    take();

    // Random single frames
    for (int r = 0; r < 5; r++) begin
      f1 = rand_frame();
      send(f1);
      wait_out(lat);
      check($sformatf("rnd%0d_latency", r), lat, N + 3);
      check_frame($sformatf("rnd%0d", r), f1);
      take();
    end

    // Back-to-back frames, in_valid and out_ready held high
    for (int i = 0; i < 4; i++) bb[i] = rand_frame();
    idx = 0; outs = 0; cyc = 0; last_cyc = -1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (outs < 4 && cyc < 400) begin
      if (out_valid) begin
        check_frame($sformatf("b2b%0d", outs), bb[outs]);
        if (last_cyc >= 0) check($sformatf("b2b%0d_period", outs), cyc - last_cyc, N + 5);
        last_cyc = cyc;
        outs++;
      end
      if (in_ready) begin
        if (idx < 4) begin
          pos = bb[idx];
          idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clk); cyc++; @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_count", outs, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
